rs_array_param: RTL
===================

Name: rs_array_param

Overview:
- Parametrised reservation station for one functional-unit class (adder, multiplier, etc.) in the Tomasulo datapath.
- Accepts renamed instructions from the issue stage. Each operand arrives either as a value or as a producer tag.
- Snoops the common data bus (CDB) to wake up waiting operands.
- Dispatches ready operand pairs to its functional unit over a valid/ready handshake.
- Replaces the fixed 4-entry, in-order-only station with configurable depth/width, CDB capture, flush and an out-of-order issue mode.

Parameters:
- DATA_W, 8, operand data width.
- TAG_W, 3, producer/station tag width.
- DEPTH, 4, number of entries (2..16).
- TAG_BASE, 0, tag of entry i = TAG_BASE+i. Elaboration error unless TAG_BASE+DEPTH <= 2**TAG_W.
- IN_ORDER, 1, 1 = FIFO allocate/issue (head/tail ring); 0 = allocate lowest free index, issue any ready entry round-robin.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all entries.
- alloc_valid  in  1  issue stage presents an instruction.
- alloc_ready  out  1  station can accept (= !full).
- alloc_op1_vbit / alloc_op2_vbit  in  1 each  operand holds a value (1) or waits on a tag (0).
- alloc_op1_tag / alloc_op2_tag  in  TAG_W each  producer tag, meaningful when vbit=0.
- alloc_op1 / alloc_op2  in  DATA_W each  operand value, meaningful when vbit=1.
- alloc_tag  out  TAG_W  tag the entry being allocated this cycle receives.
- cdb_valid  in  1  CDB broadcast this cycle.
- cdb_tag  in  TAG_W  tag of the broadcast result.
- cdb_data  in  DATA_W  broadcast result value.
- issue_valid  out  1  ready entry presented to the functional unit.
- issue_ready  in  1  functional unit accepts.
- issue_op1 / issue_op2  out  DATA_W each  operands of the presented entry.
- issue_tag  out  TAG_W  tag of the presented entry.
- full  out  1  all entries busy.
- occupancy  out  $clog2(DEPTH+1)  number of busy entries.

Behaviour:
- Reset (async, rst_n=0):
  - All entries not busy; head, tail and round-robin pointers = 0; occupancy=0.
  - full=0, alloc_ready=1, issue_valid=0, issue_op1/op2/tag=0.
  - A reset asserted mid-handshake discards all entries; nothing is issued afterwards.
- Entry state: busy, v1, t1, d1, v2, t2, d2.
- Allocation:
  - Fires on alloc_valid & alloc_ready at the rising edge.
  - Target entry: tail (IN_ORDER=1) or lowest-index free entry (IN_ORDER=0).
  - alloc_tag is combinational and = TAG_BASE+target; it is valid whenever alloc_ready=1.
  - alloc_ready reflects pre-edge state only. A full station that issues in the same cycle still reports alloc_ready=0; the freed slot is usable next cycle.
- CDB capture:
  - Each busy entry with vN=0 and tN==cdb_tag under cdb_valid loads dN=cdb_data and sets vN=1 at the edge.
  - Both operands may capture from the same broadcast.
  - Allocation bypass: an allocating operand with vbit=0 and tag==cdb_tag under cdb_valid is stored as valid with cdb_data.
- Ready condition: busy & v1 & v2, evaluated on registered state. An entry woken by the CDB at edge k is eligible for issue from cycle k+1. There is no same-cycle CDB-to-issue forwarding.
- Issue selection:
  - IN_ORDER=1: only the head entry is eligible.
  - IN_ORDER=0: first ready entry scanning from rr_ptr upward with wrap-around. rr_ptr moves to (issued index+1) mod DEPTH on each issue.
  - issue_* outputs are driven combinationally from the selected entry.
  - Stall lock: while issue_valid=1 & issue_ready=0, the selected entry and issue_op1/op2/tag hold stable. A newly ready entry does not displace the selection.
- Issue handshake: on issue_valid & issue_ready the selected entry clears busy at the edge. IN_ORDER=1 also advances head.
- occupancy: +1 on alloc only, -1 on issue only, unchanged when both fire. full = (occupancy==DEPTH).
- flush:
  - At the edge, clears every entry and all pointers and sets occupancy=0.
  - Overrides any alloc, issue or CDB capture in the same cycle.
  - issue_valid is still combinationally high during the flush cycle if an entry was ready. The functional unit must ignore a handshake coinciding with flush.
- Pointer wrap: head, tail and rr_ptr wrap DEPTH-1 -> 0. No power-of-two DEPTH is required.

Test Plan:
1. Defaults: allocate (op1 v=1 0x0A, op2 v=1 0x05) with issue_ready=1 -> next cycle issue_valid=1, op1=0x0A, op2=0x05, issue_tag=0; occupancy 1->0.
2. Fill/full: 4 allocations with op2 waiting on tag 5 -> alloc_tag 0,1,2,3; full=1, alloc_ready=0; a 5th alloc_valid is ignored and occupancy stays 4.
3. CDB wakeup: entry 1 waits on tag 5; cdb (5, 0x33) at edge k -> entry 1 d2=0x33, issue_valid rises in cycle k+1, not k.
4. Allocation bypass: allocate with op1 tag 6 while cdb (6, 0x77) -> entry stored with v1=1, d1=0x77.
5. IN_ORDER=0, DEPTH=4: entries 0 and 2 waiting, 1 and 3 ready, issue_ready held 0 for 3 cycles -> issue_tag=1 stays stable; after accept, next issue is tag 3 (round-robin), not 0.
6. Flush while full with a stalled issue -> next cycle occupancy=0, issue_valid=0, alloc_ready=1. Async reset mid-stall -> all outputs at reset values immediately.

Source files
------------

// File: rtl/rs_array_param.sv
// Parametrised Tomasulo reservation station for one functional-unit class.
// Holds renamed instructions until both operands are available. Waiting
// operands are woken by snooping the CDB. Ready entries are handed to the
// functional unit over a valid/ready handshake, either strictly in
// allocation order (head/tail ring) or out of order with round-robin
// fairness.
module rs_array_param #(
  parameter int DATA_W   = 8,
  parameter int TAG_W    = 3,
  parameter int DEPTH    = 4,
  parameter int TAG_BASE = 0,
  parameter bit IN_ORDER = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  // allocation from the issue stage
  input  logic                         alloc_valid,
  output logic                         alloc_ready,
  input  logic                         alloc_op1_vbit,
  input  logic                         alloc_op2_vbit,
  input  logic [TAG_W-1:0]             alloc_op1_tag,
  input  logic [TAG_W-1:0]             alloc_op2_tag,
  input  logic [DATA_W-1:0]            alloc_op1,
  input  logic [DATA_W-1:0]            alloc_op2,
  output logic [TAG_W-1:0]             alloc_tag,
  // common data bus snoop
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [DATA_W-1:0]            cdb_data,
  // dispatch to the functional unit
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [DATA_W-1:0]            issue_op1,
  output logic [DATA_W-1:0]            issue_op2,
  output logic [TAG_W-1:0]             issue_tag,
  // status
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic              busy;
    logic              v1;
    logic [TAG_W-1:0]  t1;
    logic [DATA_W-1:0] d1;
    logic              v2;
    logic [TAG_W-1:0]  t2;
    logic [DATA_W-1:0] d2;
  } entry_t;

  // Reject configurations whose tags would not fit or whose depth is
  // outside the supported range.
  if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
    $error("rs_array_param: DEPTH must be in 2..16");
  end
  if (TAG_BASE + DEPTH > 2**TAG_W) begin : g_bad_tag
    $error("rs_array_param: TAG_BASE+DEPTH exceeds the tag space");
  end

  // Ring increment that wraps at DEPTH-1, so DEPTH need not be a power of two.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH-1)) ? '0 : ptr_t'(p + ptr_t'(1));
  endfunction

  // base + k modulo DEPTH, for k in 0..DEPTH-1.
  function automatic ptr_t ptr_add(input ptr_t base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= DEPTH) s = s - DEPTH;
    return ptr_t'(s);
  endfunction

  function automatic logic [TAG_W-1:0] idx_to_tag(input ptr_t idx);
    return TAG_W'(TAG_BASE + int'(idx));
  endfunction

  entry_t ent_q [DEPTH];
  entry_t ent_d [DEPTH];
  ptr_t   head_q, head_d;
  ptr_t   tail_q, tail_d;
  ptr_t   rr_q, rr_d;
  cnt_t   occ_q, occ_d;
  // Stall lock: remembers the presented entry while the unit holds it off,
  // so a newly woken entry cannot steal the slot mid-handshake.
  logic   lock_q, lock_d;
  ptr_t   lock_idx_q, lock_idx_d;

  logic [DEPTH-1:0] rdy;
  ptr_t             free_idx;
  ptr_t             rr_sel;
  logic             rr_found;
  ptr_t             sel_idx;
  logic             sel_valid;
  ptr_t             target;
  logic             alloc_fire;
  logic             issue_fire;
  logic             byp1;
  logic             byp2;

  // Per-entry readiness and lowest-index free slot from registered state.
  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    rdy      = '0;
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      rdy[i] = ent_q[i].busy & ent_q[i].v1 & ent_q[i].v2;
      if (!ent_q[i].busy) free_idx = ptr_t'(i);
    end
  end

  // Round-robin scan: first ready entry at or after rr_q, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!rr_found && rdy[ptr_add(rr_q, k)]) begin
        rr_found = 1'b1;
        rr_sel   = ptr_add(rr_q, k);
      end
    end
  end

  // Choose the presented entry: head in FIFO mode, locked or scanned entry otherwise.
  always_comb begin
    if (IN_ORDER) begin
      sel_idx   = head_q;
      sel_valid = rdy[head_q];
    end else if (lock_q) begin
      sel_idx   = lock_idx_q;
      sel_valid = 1'b1;
    end else begin
      sel_idx   = rr_sel;
      sel_valid = rr_found;
    end
  end

  assign full        = (occ_q == cnt_t'(DEPTH));
  assign alloc_ready = ~full;
  assign occupancy   = occ_q;
  assign target      = IN_ORDER ? tail_q : free_idx;
  assign alloc_tag   = idx_to_tag(target);
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign issue_fire  = sel_valid & issue_ready;
  assign byp1        = ~alloc_op1_vbit & cdb_valid & (alloc_op1_tag == cdb_tag);
  assign byp2        = ~alloc_op2_vbit & cdb_valid & (alloc_op2_tag == cdb_tag);

  // Present the selected entry; outputs read zero when nothing is ready.
  always_comb begin
    issue_valid = sel_valid;
    issue_op1   = '0;
    issue_op2   = '0;
    issue_tag   = '0;
    if (sel_valid) begin
      issue_op1 = ent_q[sel_idx].d1;
      issue_op2 = ent_q[sel_idx].d2;
      issue_tag = idx_to_tag(sel_idx);
    end
  end

  // Entry next state: CDB capture, issue release, allocation, then flush on top.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].busy && cdb_valid) begin
        if (!ent_q[i].v1 && ent_q[i].t1 == cdb_tag) begin
          ent_d[i].v1 = 1'b1;
          ent_d[i].d1 = cdb_data;
        end
        if (!ent_q[i].v2 && ent_q[i].t2 == cdb_tag) begin
          ent_d[i].v2 = 1'b1;
          ent_d[i].d2 = cdb_data;
        end
      end
      // the issued entry is busy and the target is free, so these never collide
      if (issue_fire && sel_idx == ptr_t'(i)) ent_d[i].busy = 1'b0;
      if (alloc_fire && target == ptr_t'(i)) begin
        ent_d[i].busy = 1'b1;
        ent_d[i].v1   = alloc_op1_vbit | byp1;
        ent_d[i].t1   = alloc_op1_tag;
        ent_d[i].d1   = byp1 ? cdb_data : alloc_op1;
        ent_d[i].v2   = alloc_op2_vbit | byp2;
        ent_d[i].t2   = alloc_op2_tag;
        ent_d[i].d2   = byp2 ? cdb_data : alloc_op2;
      end
      if (flush) ent_d[i] = '0;
    end
  end

  // Pointer, occupancy and stall-lock next state; flush clears everything.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    rr_d       = rr_q;
    occ_d      = occ_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (issue_fire) begin
      head_d = ptr_inc(head_q);
      rr_d   = ptr_inc(sel_idx);
      lock_d = 1'b0;
    end else if (sel_valid) begin
      lock_d     = 1'b1;
      lock_idx_d = sel_idx;
    end
    if (alloc_fire) tail_d = ptr_inc(tail_q);
    if (alloc_fire && !issue_fire)      occ_d = occ_q + cnt_t'(1);
    else if (!alloc_fire && issue_fire) occ_d = occ_q - cnt_t'(1);
    if (flush) begin
      head_d     = '0;
      tail_d     = '0;
      rr_d       = '0;
      occ_d      = '0;
      lock_d     = 1'b0;
      lock_idx_d = '0;
    end
  end

  // State registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the entry array is small and its busy bits must come up clear, so
  // it is reset along with the pointers rather than left as plain storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      rr_q       <= '0;
      occ_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      head_q     <= head_d;
      tail_q     <= tail_d;
      rr_q       <= rr_d;
      occ_q      <= occ_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule
